// File: rtl/result_stream_tx_if.sv
// Word stream between result_stream_tx and the SPI slave transmitter.
// Optional macro RESULT_STREAM_LAST_EN adds spi_word_last to the stream.
//
// Handshake: a word transfers on every rising clk edge where
// spi_word_valid && spi_word_ready are both high. Once the master raises
// spi_word_valid it holds valid and data (and last) unchanged until that
// transfer happens; ready may toggle freely and never gates valid.
interface result_stream_tx_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  spi_word_valid;
    logic [DATA_WIDTH-1:0] spi_word_out;
    logic                  spi_word_ready;
`ifdef RESULT_STREAM_LAST_EN
    logic                  spi_word_last;

    modport master (
        output spi_word_valid,
        output spi_word_out,
        output spi_word_last,
        input  spi_word_ready
    );

    modport slave (
        input  spi_word_valid,
        input  spi_word_out,
        input  spi_word_last,
        output spi_word_ready
    );
`else
    modport master (
        output spi_word_valid,
        output spi_word_out,
        input  spi_word_ready
    );

    modport slave (
        input  spi_word_valid,
        input  spi_word_out,
        output spi_word_ready
    );
`endif
endinterface

// File: rtl/result_stream_tx.sv
// result_stream_tx: captures D_MODEL-word result columns into two ping-pong
// banks and serializes them word 0 first onto a valid/ready word stream.
// Capture and transmission overlap, so one column fills while the other drains.
// Optional macro RESULT_STREAM_LAST_EN adds spi_word_last (marks word D_MODEL-1).
module result_stream_tx #(
    parameter int  D_MODEL    = 64,
    parameter int  DATA_WIDTH = 16,
    localparam int IDX_W      = $clog2(D_MODEL)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          col_valid,
    input  logic [D_MODEL*DATA_WIDTH-1:0] col_in,
    output logic                          col_ready,
    result_stream_tx_if.master            spi,
    output logic                          stream_done,
    output logic                          overflow,
    output logic                          dbg_state_o,
    output logic [IDX_W-1:0]              dbg_col_cnt_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(D_MODEL - 1);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] bank_q [2][D_MODEL];
    logic [1:0]            full_q, full_d;
    logic                  wr_sel_q, wr_sel_d;
    logic                  rd_sel_q, rd_sel_d;
    logic [IDX_W-1:0]      word_idx_q, word_idx_d;
    logic [IDX_W-1:0]      col_cnt_q, col_cnt_d;
    logic                  overflow_q, overflow_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  done_q, done_d;
`ifdef RESULT_STREAM_LAST_EN
    logic                  last_q, last_d;
`endif

    logic capture;
    logic accept;
    logic last_word;

    // Readiness comes only from registered flags, so a bank freed this very
    // cycle is not yet visible to the capture side.
    assign col_ready = ~full_q[wr_sel_q];
    assign capture   = col_valid & col_ready;
    assign accept    = valid_q & spi.spi_word_ready;
    assign last_word = (word_idx_q == LAST_IDX);

    assign spi.spi_word_valid = valid_q;
    assign spi.spi_word_out   = out_q;
`ifdef RESULT_STREAM_LAST_EN
    assign spi.spi_word_last  = last_q;
`endif
    assign stream_done   = done_q;
    assign overflow      = overflow_q;
    assign dbg_state_o   = state_q;
    assign dbg_col_cnt_o = col_cnt_q;

    // State register: FSM, bank bookkeeping and registered stream outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            full_q     <= 2'b00;
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            word_idx_q <= '0;
            col_cnt_q  <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            out_q      <= '0;
            done_q     <= 1'b0;
`ifdef RESULT_STREAM_LAST_EN
            last_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            full_q     <= full_d;
            wr_sel_q   <= wr_sel_d;
            rd_sel_q   <= rd_sel_d;
            word_idx_q <= word_idx_d;
            col_cnt_q  <= col_cnt_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
            out_q      <= out_d;
            done_q     <= done_d;
`ifdef RESULT_STREAM_LAST_EN
            last_q     <= last_d;
`endif
        end
    end

    // Bank storage: a whole column lands in the write bank in one cycle.
    always_ff @(posedge clk) begin
        if (!rst && capture) begin
            for (int k = 0; k < D_MODEL; k++) begin
                bank_q[wr_sel_q][k] <= col_in[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state: transmit sequencing, read bank hand-over and column count.
    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        rd_sel_d   = rd_sel_q;
        col_cnt_d  = col_cnt_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (full_q[rd_sel_q]) begin
                    state_d    = S_SEND;
                    word_idx_d = '0;
                end
            end
            S_SEND: begin
                if (accept) begin
                    if (!last_word) begin
                        word_idx_d = word_idx_q + IDX_W'(1);
                    end else begin
                        rd_sel_d   = ~rd_sel_q;
                        word_idx_d = '0;
                        done_d     = (col_cnt_q == LAST_IDX);
                        col_cnt_d  = (col_cnt_q == LAST_IDX) ? '0 : col_cnt_q + IDX_W'(1);
                        // Other bank already full: continue with no bubble.
                        state_d    = full_q[~rd_sel_q] ? S_SEND : S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Next-state: bank full flags, write select and sticky overflow.
    always_comb begin
        full_d     = full_q;
        wr_sel_d   = wr_sel_q;
        overflow_d = overflow_q;
        // Freeing and filling never hit the same bank: filling needs it
        // empty, freeing needs it full.
        if (state_q == S_SEND && accept && last_word) begin
            full_d[rd_sel_q] = 1'b0;
        end
        if (col_valid) begin
            if (col_ready) begin
                full_d[wr_sel_q] = 1'b1;
                wr_sel_d         = ~wr_sel_q;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    // Output decode: the word presented next cycle follows the next state,
    // which keeps data stable while ready is low.
    always_comb begin
        valid_d = (state_d == S_SEND);
        out_d   = valid_d ? bank_q[rd_sel_d][word_idx_d] : '0;
`ifdef RESULT_STREAM_LAST_EN
        last_d  = valid_d && (word_idx_d == LAST_IDX);
`endif
    end

endmodule

// File: tb/tb_result_stream_tx.sv
// Directed bench for result_stream_tx (default D_MODEL=64, DATA_WIDTH=16).
// Inputs are driven and outputs sampled on the falling edge.
module tb_result_stream_tx;

    localparam int DM = 64;
    localparam int DW = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             col_valid = 1'b0;
    logic [DM*DW-1:0] col_in = '0;
    logic             col_ready;
    logic             stream_done;
    logic             overflow;
    logic             dbg_state;
    logic [5:0]       dbg_col_cnt;

    int checks   = 0;
    int failures = 0;

    result_stream_tx_if #(.DATA_WIDTH(DW)) s_if ();

    result_stream_tx #(.D_MODEL(DM), .DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .col_valid     (col_valid),
        .col_in        (col_in),
        .col_ready     (col_ready),
        .spi           (s_if),
        .stream_done   (stream_done),
        .overflow      (overflow),
        .dbg_state_o   (dbg_state),
        .dbg_col_cnt_o (dbg_col_cnt)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [DM*DW-1:0] make_col(input logic [DW-1:0] base);
        logic [DM*DW-1:0] c;
        for (int k = 0; k < DM; k++) c[k*DW +: DW] = base + DW'(k);
        return c;
    endfunction

    // Driver: hold reset for two edges, release on a falling edge.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        col_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Driver: one-cycle col_valid pulse; returns on the negedge after capture.
    task automatic send_col(input logic [DW-1:0] base);
        col_in    = make_col(base);
        col_valid = 1'b1;
        @(negedge clk);
        col_valid = 1'b0;
    endtask

    task automatic test_reset();
        s_if.spi_word_ready = 1'b0;
        do_reset();
        checks++; if (s_if.spi_word_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %0b expected 0", s_if.spi_word_valid); end
        checks++; if (s_if.spi_word_out !== 16'h0000) begin failures++; $display("FAIL rst_out: got %h expected 0000", s_if.spi_word_out); end
        checks++; if (stream_done !== 1'b0) begin failures++; $display("FAIL rst_done: got %0b expected 0", stream_done); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_overflow: got %0b expected 0", overflow); end
        checks++; if (col_ready !== 1'b1) begin failures++; $display("FAIL rst_col_ready: got %0b expected 1", col_ready); end
        checks++; if (dbg_state !== 1'b0) begin failures++; $display("FAIL rst_state: got %0b expected 0", dbg_state); end
        checks++; if (dbg_col_cnt !== 6'd0) begin failures++; $display("FAIL rst_col_cnt: got %0d expected 0", dbg_col_cnt); end
    endtask

    task automatic test_single_column();
        s_if.spi_word_ready = 1'b1;
        @(negedge clk);
        send_col(16'h1000);
        // N+1: flag set, stream not yet valid
        checks++; if (s_if.spi_word_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid: got %0b expected 0", s_if.spi_word_valid); end
        @(negedge clk);
        for (int k = 0; k < DM; k++) begin
            checks++; if (s_if.spi_word_valid !== 1'b1) begin failures++; $display("FAIL single_valid[%0d]: got %0b expected 1", k, s_if.spi_word_valid); end
            checks++; if (s_if.spi_word_out !== 16'h1000 + 16'(k)) begin failures++; $display("FAIL single_word[%0d]: got %h expected %h", k, s_if.spi_word_out, 16'h1000 + 16'(k)); end
`ifdef RESULT_STREAM_LAST_EN
            checks++; if (s_if.spi_word_last !== (k == DM - 1)) begin failures++; $display("FAIL single_last[%0d]: got %0b expected %0b", k, s_if.spi_word_last, (k == DM - 1)); end
`endif
            @(negedge clk);
        end
        checks++; if (s_if.spi_word_valid !== 1'b0) begin failures++; $display("FAIL single_tail_valid: got %0b expected 0", s_if.spi_word_valid); end
        checks++; if (col_ready !== 1'b1) begin failures++; $display("FAIL single_col_ready: got %0b expected 1", col_ready); end
    endtask

    task automatic test_backpressure();
        int idx;
        int cyc;
        idx = 0;
        cyc = 0;
        send_col(16'h2000);
        while (idx < DM && cyc < 400) begin
            s_if.spi_word_ready = (cyc % 2 == 0);
            if (s_if.spi_word_valid) begin
                checks++; if (s_if.spi_word_out !== 16'h2000 + 16'(idx)) begin failures++; $display("FAIL bp_word[%0d]: got %h expected %h", idx, s_if.spi_word_out, 16'h2000 + 16'(idx)); end
                if (s_if.spi_word_ready) idx++;
            end
            @(negedge clk);
            cyc++;
        end
        checks++; if (idx !== DM) begin failures++; $display("FAIL bp_count: got %0d expected %0d", idx, DM); end
        checks++; if (s_if.spi_word_valid !== 1'b0) begin failures++; $display("FAIL bp_tail_valid: got %0b expected 0", s_if.spi_word_valid); end
        s_if.spi_word_ready = 1'b1;
    endtask

    task automatic test_ping_pong();
        logic [DW-1:0] exp_q[$];
        int got;
        int first;
        int last;
        got = 0;
        first = -1;
        last = -1;
        for (int k = 0; k < DM; k++) exp_q.push_back(16'h3000 + 16'(k));
        for (int k = 0; k < DM; k++) exp_q.push_back(16'h4000 + 16'(k));
        s_if.spi_word_ready = 1'b1;
        for (int c = 0; c < 200; c++) begin
            col_valid = (c == 0 || c == 3);
            col_in    = make_col((c < 3) ? 16'h3000 : 16'h4000);
            if (s_if.spi_word_valid) begin
                if (first < 0) first = c;
                last = c;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL pp_extra_word: got %h expected none", s_if.spi_word_out);
                end else if (s_if.spi_word_out !== exp_q[0]) begin
                    failures++; $display("FAIL pp_word[%0d]: got %h expected %h", got, s_if.spi_word_out, exp_q[0]);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                got++;
            end
            @(negedge clk);
        end
        col_valid = 1'b0;
        checks++; if (first !== 2) begin failures++; $display("FAIL pp_first_cycle: got %0d expected 2", first); end
        checks++; if (got !== 2 * DM) begin failures++; $display("FAIL pp_count: got %0d expected %0d", got, 2 * DM); end
        checks++; if (last - first + 1 !== 2 * DM) begin failures++; $display("FAIL pp_contiguous: got %0d expected %0d", last - first + 1, 2 * DM); end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] exp_q[$];
        int got;
        got = 0;
        for (int k = 0; k < DM; k++) exp_q.push_back(16'h5000 + 16'(k));
        for (int k = 0; k < DM; k++) exp_q.push_back(16'h6000 + 16'(k));
        s_if.spi_word_ready = 1'b0;
        send_col(16'h5000);
        send_col(16'h6000);
        checks++; if (col_ready !== 1'b0) begin failures++; $display("FAIL ov_col_ready: got %0b expected 0", col_ready); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ov_before: got %0b expected 0", overflow); end
        send_col(16'h7000);
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ov_set: got %0b expected 1", overflow); end
        repeat (5) @(negedge clk);
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ov_sticky: got %0b expected 1", overflow); end
        checks++; if (s_if.spi_word_out !== 16'h5000) begin failures++; $display("FAIL ov_hold_word: got %h expected 5000", s_if.spi_word_out); end
        s_if.spi_word_ready = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (s_if.spi_word_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL ov_extra_word: got %h expected none", s_if.spi_word_out);
                end else if (s_if.spi_word_out !== exp_q[0]) begin
                    failures++; $display("FAIL ov_word[%0d]: got %h expected %h", got, s_if.spi_word_out, exp_q[0]);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                got++;
            end
            @(negedge clk);
        end
        checks++; if (got !== 2 * DM) begin failures++; $display("FAIL ov_count: got %0d expected %0d", got, 2 * DM); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ov_sticky_end: got %0b expected 1", overflow); end
    endtask

    task automatic test_full_run();
        int sent;
        int got;
        int last_c;
        int done_c;
        int done_n;
        sent = 0;
        got = 0;
        last_c = -1;
        done_c = -1;
        done_n = 0;
        do_reset();
        s_if.spi_word_ready = 1'b1;
        for (int c = 0; c < 6000; c++) begin
            col_valid = col_ready && (sent < DM);
            col_in    = make_col(16'(sent * DM));
            if (col_valid) sent++;
            if (stream_done) begin
                done_n++;
                done_c = c;
                checks++; if (dbg_col_cnt !== 6'd0) begin failures++; $display("FAIL run_col_cnt_at_done: got %0d expected 0", dbg_col_cnt); end
            end
            if (s_if.spi_word_valid) begin
                checks++; if (s_if.spi_word_out !== 16'(got)) begin failures++; $display("FAIL run_word[%0d]: got %h expected %h", got, s_if.spi_word_out, 16'(got)); end
                got++;
                last_c = c;
            end
            @(negedge clk);
            if (got == DM * DM && c > last_c + 3) break;
        end
        col_valid = 1'b0;
        checks++; if (got !== DM * DM) begin failures++; $display("FAIL run_count: got %0d expected %0d", got, DM * DM); end
        checks++; if (done_n !== 1) begin failures++; $display("FAIL run_done_count: got %0d expected 1", done_n); end
        checks++; if (done_c !== last_c + 1) begin failures++; $display("FAIL run_done_cycle: got %0d expected %0d", done_c, last_c + 1); end
        checks++; if (dbg_col_cnt !== 6'd0) begin failures++; $display("FAIL run_col_cnt_end: got %0d expected 0", dbg_col_cnt); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL run_overflow: got %0b expected 0", overflow); end
    endtask

    task automatic test_reset_mid_stream();
        int seen;
        int c;
        seen = 0;
        c = 0;
        s_if.spi_word_ready = 1'b1;
        send_col(16'h8000);
        while (seen < 10 && c < 50) begin
            if (s_if.spi_word_valid) seen++;
            @(negedge clk);
            c++;
        end
        checks++; if (seen !== 10) begin failures++; $display("FAIL mid_words_before: got %0d expected 10", seen); end
        checks++; if (s_if.spi_word_out !== 16'h800A) begin failures++; $display("FAIL mid_word10: got %h expected 800a", s_if.spi_word_out); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (s_if.spi_word_valid !== 1'b0) begin failures++; $display("FAIL mid_valid: got %0b expected 0", s_if.spi_word_valid); end
        checks++; if (col_ready !== 1'b1) begin failures++; $display("FAIL mid_col_ready: got %0b expected 1", col_ready); end
        checks++; if (s_if.spi_word_out !== 16'h0000) begin failures++; $display("FAIL mid_out: got %h expected 0000", s_if.spi_word_out); end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++; if (s_if.spi_word_valid !== 1'b0) begin failures++; $display("FAIL mid_idle_valid[%0d]: got %0b expected 0", k, s_if.spi_word_valid); end
        end
        send_col(16'h9000);
        @(negedge clk);
        checks++; if (s_if.spi_word_valid !== 1'b1) begin failures++; $display("FAIL mid_restart_valid: got %0b expected 1", s_if.spi_word_valid); end
        checks++; if (s_if.spi_word_out !== 16'h9000) begin failures++; $display("FAIL mid_restart_word: got %h expected 9000", s_if.spi_word_out); end
    endtask

    initial begin
        s_if.spi_word_ready = 1'b0;
        test_reset();
        test_single_column();
        test_backpressure();
        test_ping_pong();
        test_overflow();
        test_full_run();
        test_reset_mid_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/result_stream_tx.md
# result_stream_tx

Transmit-side counterpart of the column streaming controller. Captures each D_MODEL-wide LayerNorm result column (one-cycle `col_valid` pulse) into one of two ping-pong banks, then serializes the banks word-by-word onto a valid/ready word stream toward the SPI slave transmitter. Capture and transmission run concurrently, so one column can be captured while the previous one drains.

## Interface
- `D_MODEL`, 64, words per column and columns per run
- `DATA_WIDTH`, 16, bits per word
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `col_valid`  in  1  one-cycle pulse; `col_in` holds a complete result column
- `col_in`  in  D_MODEL*DATA_WIDTH  column; word k is `col_in[k*DATA_WIDTH +: DATA_WIDTH]`
- `col_ready`  out  1  level; the current write bank is empty
- `spi_word_valid`  out  1  `spi_word_out` is valid
- `spi_word_out`  out  DATA_WIDTH  outgoing word
- `spi_word_ready`  in  1  sink accepts the word this cycle
- `stream_done`  out  1  one-cycle pulse after the last word of column D_MODEL-1 is accepted
- `overflow`  out  1  sticky; a column was dropped

## Operation
- State: banks A and B (D_MODEL x DATA_WIDTH each), `full_A`, `full_B`, `wr_sel`, `rd_sel`, `word_idx` (log2 D_MODEL bits), `col_cnt` (log2 D_MODEL bits).
- Capture:
  - `col_ready = ~full[wr_sel]`, combinational from registered flags.
  - If `col_valid && col_ready`: copy `col_in` into bank[wr_sel], set full[wr_sel], toggle `wr_sel`.
  - If `col_valid && !col_ready`: drop the column and set `overflow`. `overflow` clears only on `rst`.
- Transmit FSM, S_IDLE / S_SEND:
  - S_IDLE: if full[rd_sel], go to S_SEND with `word_idx` = 0.
  - S_SEND: `spi_word_valid` = 1, `spi_word_out` = bank[rd_sel][word_idx].
  - On `spi_word_valid && spi_word_ready`: if `word_idx` < D_MODEL-1, increment it.
  - Otherwise (last word): clear full[rd_sel], toggle `rd_sel`, reset `word_idx` to 0, and advance `col_cnt`. Stay in S_SEND if the other bank is full, else go to S_IDLE.
- `col_cnt` wraps D_MODEL-1 -> 0. `stream_done` pulses on that wrap.
- Simultaneous bank free and capture into the same bank in one cycle: `col_ready` reflects flags before the edge, so the capture is refused and `overflow` is set. Upstream must see `col_ready` high before pulsing.
- Word order is word 0 first (LSB slice of `col_in`), word D_MODEL-1 last.
- No arithmetic on data. Words pass bit-exact.

## Timing
- Reset values:
  - `spi_word_valid` = 0, `spi_word_out` = 0, `stream_done` = 0, `overflow` = 0, `col_ready` = 1.
  - Both banks empty, `wr_sel` = `rd_sel` = A, `col_cnt` = `word_idx` = 0, state S_IDLE.
- Capture to first word: `col_valid` at cycle N (banks empty) -> full_A at N+1 -> `spi_word_valid` high at N+2 with word 0.
- With `spi_word_ready` held high, one word per cycle. A column drains in D_MODEL cycles.
- Back-to-back banks: word 0 of the next bank is presented the cycle after the previous last word is accepted, with no bubble.
- `spi_word_valid`/`spi_word_out` are registered and held stable while `spi_word_ready` is low. Valid never drops without acceptance, except on `rst`.
- `stream_done` is high the cycle after the last accepted word of column D_MODEL-1, for exactly one cycle.
- `rst` mid-stream: all buffered and in-flight words are discarded and outputs take reset values on the next edge. No partial column is resumed.

## Configuration
- `RESULT_STREAM_LAST_EN`
  - Defined: adds output `spi_word_last` (1 bit, reset 0), high together with `spi_word_valid` on word D_MODEL-1 of each column.
  - Undefined: the port does not exist and all other behaviour is identical.

## Test plan
- Single column: `col_in` word k = 16'h1000+k, `spi_word_ready` = 1.
  - Expect `spi_word_valid` at N+2 and words 1000..103F in order, one per cycle.
  - Expect `col_ready` back high the cycle after 103F is accepted.
- Backpressure: same column with `spi_word_ready` toggling 1/0.
  - Expect each word held stable until accepted, with none lost or duplicated.
- Ping-pong: two columns pulsed 3 cycles apart with ready = 1.
  - Expect 128 contiguous valid cycles and the second column starting immediately after word 63 of the first.
- Overflow: three pulses with `spi_word_ready` = 0.
  - Expect the third refused (`col_ready` = 0), `overflow` = 1 and sticky.
  - After release, only the first two columns are emitted.
- Full run: 64 columns, ready = 1.
  - Expect `stream_done` exactly once, one cycle after word 63 of column 63, and `col_cnt` back to 0.
- Reset mid-stream: assert `rst` after 10 words of column 0.
  - Expect valid = 0 and `col_ready` = 1 next cycle, and no further words until a new `col_valid`.
